tick_sample_sched: RTL
======================

Name: tick_sample_sched

Overview:
Consumes the 100 Hz square wave from the low-rate clock generator and turns each rising edge into one sensor-sample transaction. Runs entirely in the clk_100MHz domain. Issues a four-phase req/ack handshake to the sensor reader and stores the returned samples in a first-word-fall-through FIFO for the processor-side reader. Flags timeouts, missed ticks and FIFO overruns with sticky error bits.

Parameters:
DATA_W, 16, sample width in bits
FIFO_DEPTH, 8, FIFO entries; power of 2, minimum 2
TIMEOUT_CYC, 100000, clk cycles allowed in REQ before timeout (1 ms)
SYNC_STAGES, 2, synchronizer flops on tick_in; minimum 2

Ports:
clk_100MHz  in  1  system clock, 100 MHz
rst_100MHz  in  1  asynchronous reset, active-high
tick_in  in  1  100 Hz square wave; treated as asynchronous
enable  in  1  1 = new ticks start transactions
req_o  out  1  sample request to sensor reader
ack_i  in  1  sensor reader acknowledge; data_i valid while high
data_i  in  DATA_W  sample data
rd_en  in  1  pop FIFO head
rd_data  out  DATA_W  FIFO head; valid when empty=0
empty  out  1  FIFO empty
full  out  1  FIFO full
level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
sample_cnt  out  32  count of samples written to FIFO
timeout_err  out  1  sticky: handshake timed out
overrun_err  out  1  sticky: sample dropped, FIFO full
missed_tick  out  1  sticky: tick arrived while busy
clr_err  in  1  one-cycle pulse; clears all three sticky flags

Behaviour:
- Reset (asynchronous, active-high): FSM to IDLE; req_o, level, sample_cnt and all sticky flags = 0; empty = 1; full = 0; FIFO pointers and synchronizer flops = 0; timeout counter = 0.
- Tick detect: tick_in passes through SYNC_STAGES flops, followed by one edge-detect flop.
  - tick_pulse is one cycle, high on a synchronized 0->1 transition only.
  - Latency: tick_pulse is asserted SYNC_STAGES+1 cycles after tick_in rises.
  - Falling edges are ignored.
- FSM states: IDLE, REQ, RELEASE.
  - IDLE: on tick_pulse with enable=1, go to REQ. req_o rises on the next clock edge.
  - REQ: req_o=1. The timeout counter increments every cycle.
    - ack_i=1 sampled: capture data_i, attempt a FIFO write that same edge, set req_o=0, go to RELEASE.
    - Counter reaches TIMEOUT_CYC-1 with no ack: set timeout_err, set req_o=0, go to IDLE, write nothing.
  - RELEASE: req_o=0. Wait for ack_i=0, then go to IDLE. No timeout in this state.
  - The timeout counter clears on entry to REQ.
- tick_pulse with enable=1 while FSM is not IDLE: set missed_tick; drop the tick; current transaction unaffected.
- enable=0: ticks are ignored and do not set missed_tick. An in-flight transaction still completes.
- FIFO write rules:
  - Write when not full.
  - Write when full with rd_en=1 on the same cycle: pop and push both occur, level unchanged.
  - Write when full with no pop: sample discarded, overrun_err set, sample_cnt not incremented.
- sample_cnt: +1 per accepted write; wraps 0xFFFFFFFF -> 0.
- FIFO read:
  - rd_data = mem[rd_ptr], combinational (first-word fall-through).
  - rd_en with empty=1 is ignored: no pointer or level change.
  - Push while empty: data appears on rd_data and empty=0 one cycle after the write edge.
- Pointers are clog2(FIFO_DEPTH)+1 bits and wrap naturally. full = (level==FIFO_DEPTH); empty = (level==0).
- Sticky flags:
  - clr_err clears all three flags.
  - If a set condition and clr_err occur on the same cycle, set wins.
- Reset mid-transaction: req_o drops immediately (asynchronous). FIFO contents are discarded. ack_i still high after reset release is ignored until the next REQ.

Test Plan:
- Reset, then tick_in 0->1 with enable=1 -> req_o=1 exactly SYNC_STAGES+2 cycles after the edge. ack_i=1 two cycles later with data_i=0xA5A5 -> req_o=0, empty=0, rd_data=0xA5A5, level=1, sample_cnt=1.
- Bench TIMEOUT_CYC=50, ack_i held 0 -> req_o high for exactly 50 cycles, then timeout_err=1, FSM back in IDLE, level unchanged. clr_err pulse -> timeout_err=0.
- FIFO_DEPTH=8: nine ticks/acks with no reads -> full=1 after the 8th. The 9th sets overrun_err, sample_cnt=8. Eight rd_en pops return samples in order, then empty=1.
- Second tick_in edge while ack_i is held high in RELEASE -> missed_tick=1, no second req_o pulse. Drop ack_i -> IDLE. The next tick produces a normal transaction.
- enable=0 during a tick -> no req_o, missed_tick stays 0. rd_en while empty -> level stays 0.
- Assert rst_100MHz while in REQ -> req_o=0 in the same cycle, level=0, empty=1, all flags 0.

Source files
------------

// File: rtl/tick_sample_sched.sv
// Turns each synchronized rising edge of the 100 Hz tick into one req/ack sensor
// sample transaction and buffers the returned samples in a fall-through FIFO.
//
// state   | meaning
// IDLE    | waiting for a tick with enable set
// REQ     | req_o high, waiting for ack_i or timeout
// RELEASE | req_o low, waiting for ack_i to drop
module tick_sample_sched #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk_100MHz,
    input  logic                          rst_100MHz,
    input  logic                          tick_in,
    input  logic                          enable,
    output logic                          req_o,
    input  logic                          ack_i,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [31:0]                   sample_cnt,
    output logic                          timeout_err,
    output logic                          overrun_err,
    output logic                          missed_tick,
    input  logic                          clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RELEASE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic                   tick_pulse;
    logic [CW-1:0]          to_cnt;
    logic                   wr_attempt;
    logic                   timeout_hit;
    logic                   missed_hit;
    logic                   do_push;
    logic                   do_pop;
    logic                   overrun_hit;

    logic [DATA_W-1:0]      mem [FIFO_DEPTH];
    logic [LW-1:0]          wr_ptr;
    logic [LW-1:0]          rd_ptr;

    // Pulse is registered so it lands SYNC_STAGES+1 cycles after the raw edge.
    always_ff @(posedge clk_100MHz or posedge rst_100MHz) begin
        if (rst_100MHz) begin
            sync_q     <= '0;
            sync_d     <= 1'b0;
            tick_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], tick_in};
            sync_d     <= sync_q[SYNC_STAGES-1];
            tick_pulse <= sync_q[SYNC_STAGES-1] & ~sync_d;
        end
    end

    always_ff @(posedge clk_100MHz or posedge rst_100MHz) begin
        if (rst_100MHz) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // req_o decodes straight from the state register so reset drops it at once.
    always_comb begin
        state_nxt   = state;
        req_o       = 1'b0;
        wr_attempt  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick_pulse && enable) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                req_o = 1'b1;
                if (ack_i) begin
                    wr_attempt = 1'b1;
                    state_nxt  = ST_RELEASE;
                end else if (to_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (!ack_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign missed_hit = tick_pulse && enable && (state != ST_IDLE);

    always_ff @(posedge clk_100MHz or posedge rst_100MHz) begin
        if (rst_100MHz) begin
            to_cnt <= '0;
        end else if (state != ST_REQ) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign full        = (level == DEPTH_L);
    assign empty       = (level == '0);
    assign do_pop      = rd_en && !empty;
    assign do_push     = wr_attempt && (!full || do_pop);
    assign overrun_hit = wr_attempt && full && !do_pop;
    assign rd_data     = mem[rd_ptr[AW-1:0]];

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clk_100MHz) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_100MHz or posedge rst_100MHz) begin
        if (rst_100MHz) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            sample_cnt <= '0;
        end else begin
            if (do_push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                sample_cnt <= sample_cnt + 32'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

    // A set condition outranks a simultaneous clear.
    always_ff @(posedge clk_100MHz or posedge rst_100MHz) begin
        if (rst_100MHz) begin
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
            missed_tick <= 1'b0;
        end else begin
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
            if (overrun_hit) begin
                overrun_err <= 1'b1;
            end else if (clr_err) begin
                overrun_err <= 1'b0;
            end
            if (missed_hit) begin
                missed_tick <= 1'b1;
            end else if (clr_err) begin
                missed_tick <= 1'b0;
            end
        end
    end

endmodule
